// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access:
// one outstanding transaction, DM-first priority with an IF starvation guard, flush-kill of fetches.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                flush,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_valid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_stall,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t           state;
    logic             owner_dm;
    logic             kill;
    logic [CNT_W-1:0] starve_cnt;

    logic done_now;
    logic if_cand;
    logic dm_cand;
    logic starved;
    logic pick_if;
    logic pick_dm;
    logic if_flush;

    // A request line is still showing the transaction that just completed while its
    // valid pulse is high, so no arbitration takes place in that cycle.
    always_comb begin
        done_now = if_valid | dm_valid;
        if_cand  = if_req & ~flush & ~done_now;
        dm_cand  = dm_req & ~done_now;
        starved  = (starve_cnt == CNT_W'(STARVE_MAX));
        pick_if  = if_cand & (starved | ~dm_cand);
        pick_dm  = dm_cand & ~pick_if;
        if_flush = ~owner_dm & flush;
    end

    // Stalls are held low while reset is asserted so that every output reads 0.
    assign if_stall = rst_n & if_req & ~if_valid;
    assign dm_stall = rst_n & dm_req & ~dm_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner_dm   <= 1'b0;
            kill       <= 1'b0;
            starve_cnt <= '0;
            if_valid   <= 1'b0;
            if_rdata   <= '0;
            dm_valid   <= 1'b0;
            dm_rdata   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else begin
            if_valid <= 1'b0;
            if_rdata <= '0;
            dm_valid <= 1'b0;
            dm_rdata <= '0;

            case (state)
                IDLE: begin
                    if (pick_if || pick_dm) begin
                        state     <= ISSUE;
                        mem_req   <= 1'b1;
                        owner_dm  <= pick_dm;
                        kill      <= 1'b0;
                        mem_we    <= pick_dm & dm_we;
                        mem_addr  <= pick_dm ? dm_addr : if_addr;
                        mem_wdata <= (pick_dm && dm_we) ? dm_wdata : '0;
                        mem_be    <= pick_dm ? dm_be : '1;
                        if (pick_if) begin
                            starve_cnt <= '0;
                        end else if (if_req && !starved) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end
                end

                ISSUE: begin
                    if (if_flush) begin
                        kill <= 1'b1;
                    end
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                        kill  <= 1'b0;
                        if (owner_dm) begin
                            dm_valid <= 1'b1;
                            dm_rdata <= mem_we ? '0 : mem_rdata;
                        end else if (!(kill || flush)) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else if (if_flush) begin
                        kill <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
